// File: rtl/uart_pkg.sv
// uart_param shared types: parity modes, oversampling constants
// and the TX/RX state encodings.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: W-bit words, DEPTH entries (power of 2), head shown
// combinationally on rdata. Ports: clk, rst, push/wdata, pop, rdata, full, empty.
module uart_rx_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART, 16x oversampled. Ports: clk16x, clr,
// TX (d_in, wrn, t_empty, sending, txd), RX (rxd, rdn, d_out, r_ready,
// parity_error, frame_error, overrun). UART_RX_FIFO_EN selects a
// RX_DEPTH-entry receive FIFO instead of a single holding register.
module uart_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int RX_DEPTH    = 4
) (
  input  logic                 clk16x,
  input  logic                 clr,
  input  logic [DATA_BITS-1:0] d_in,
  input  logic                 wrn,
  output logic                 t_empty,
  output logic                 sending,
  output logic                 txd,
  input  logic                 rxd,
  input  logic                 rdn,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 r_ready,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun
);

  localparam int  W       = DATA_BITS + 2;
  localparam bit  PAR_EN  = PARITY_MODE != int'(PAR_NONE);
  localparam logic PAR_INV = PARITY_MODE == int'(PAR_ODD);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [3:0] CNT_MAX   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] CNT_MID   = 4'(MID_SAMPLE);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 ||
      STOP_BITS > 2 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0)
  begin : g_bad_cfg
    $error("uart_param: illegal parameter set");
  end

  // ---------------- transmitter ----------------
  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_hold;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic [3:0]           tx_cnt;
  logic [3:0]           tx_idx;
  logic                 tx_wr;
  logic                 tx_tick;

  assign tx_wr   = !wrn && t_empty;
  assign tx_tick = tx_cnt == CNT_MAX;

  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      tx_state <= TX_IDLE;
      tx_hold  <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      t_empty  <= 1'b1;
      sending  <= 1'b0;
      txd      <= 1'b1;
    end else begin
      if (tx_wr) begin
        tx_hold <= d_in;
        t_empty <= 1'b0;
      end
      // cnt wraps 15->0 on its own, so each tick marks a bit boundary
      if (tx_state != TX_IDLE) tx_cnt <= tx_cnt + 4'd1;
      unique case (tx_state)
        TX_IDLE: begin
          if (!t_empty) begin
            tx_sh    <= tx_hold;
            tx_par   <= ^tx_hold ^ PAR_INV;
            t_empty  <= 1'b1;
            sending  <= 1'b1;
            txd      <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            txd      <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            if (tx_idx == LAST_BIT) begin
              tx_idx <= '0;
              if (PAR_EN) begin
                txd      <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                txd      <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx_idx <= tx_idx + 4'd1;
              txd    <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
            end
          end
        end
        TX_PARITY: begin
          if (tx_tick) begin
            txd      <= 1'b1;
            tx_idx   <= '0;
            tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            if (tx_idx != LAST_STOP) begin
              tx_idx <= tx_idx + 4'd1;
            end else if (!t_empty) begin
              // back-to-back frame, no idle gap
              tx_sh    <= tx_hold;
              tx_par   <= ^tx_hold ^ PAR_INV;
              t_empty  <= 1'b1;
              txd      <= 1'b0;
              tx_idx   <= '0;
              tx_state <= TX_START;
            end else begin
              sending  <= 1'b0;
              tx_idx   <= '0;
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state;
  logic                 rx_s1, rx_s2, rx_s3;
  logic [3:0]           rx_cnt;
  logic [3:0]           rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_perr;
  logic                 rx_tick;
  logic                 rx_push;
  logic                 rx_pop;
  logic [W-1:0]         rx_word;

  assign rx_tick = rx_cnt == CNT_MAX;
  assign rx_push = (rx_state == RX_STOP) && rx_tick;
  assign rx_word = {rx_sh, rx_perr, !rx_s2};
  assign rx_pop  = !rdn && r_ready;

  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
      rx_perr  <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (rx_state != RX_IDLE) rx_cnt <= rx_cnt + 4'd1;
      unique case (rx_state)
        RX_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == CNT_MID) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_idx   <= '0;
              rx_perr  <= 1'b0;
              rx_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
            if (rx_idx == LAST_BIT) begin
              rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
            end else begin
              rx_idx <= rx_idx + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_tick) begin
            rx_perr  <= rx_s2 ^ (^rx_sh) ^ PAR_INV;
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_tick) rx_state <= rx_s2 ? RX_IDLE : RX_BREAK;
        end
        RX_BREAK: begin
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- receive store ----------------
  logic         st_full;
  logic [W-1:0] head;

`ifdef UART_RX_FIFO_EN
  logic fifo_empty;
  logic fifo_push;

  assign fifo_push = rx_push && (!st_full || rx_pop);

  uart_rx_fifo #(
    .W     (W),
    .DEPTH (RX_DEPTH)
  ) u_fifo (
    .clk   (clk16x),
    .rst   (clr),
    .push  (fifo_push),
    .wdata (rx_word),
    .pop   (rx_pop),
    .rdata (head),
    .full  (st_full),
    .empty (fifo_empty)
  );

  assign r_ready = !fifo_empty;
`else
  logic [W-1:0] hold_q;
  logic         ready_q;

  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      hold_q  <= '0;
      ready_q <= 1'b0;
    end else if (rx_push && (!ready_q || rx_pop)) begin
      hold_q  <= rx_word;
      ready_q <= 1'b1;
    end else if (rx_pop) begin
      ready_q <= 1'b0;
    end
  end

  assign head    = hold_q;
  assign st_full = ready_q;
  assign r_ready = ready_q;
`endif

  always_ff @(posedge clk16x or posedge clr) begin
    if (clr)                      overrun <= 1'b0;
    else if (rx_pop)              overrun <= 1'b0;
    else if (rx_push && st_full)  overrun <= 1'b1;
  end

  assign d_out        = r_ready ? head[W-1:2] : '0;
  assign parity_error = r_ready && head[1];
  assign frame_error  = r_ready && head[0];

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: 8-bit even-parity instance driven serially,
// plus a 5-bit odd-parity 2-stop instance in txd->rxd loopback.
module tb_uart_param;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] d_in8;
  logic       wrn8, t_empty8, sending8, txd8, rxd8, rdn8;
  logic [7:0] d_out8;
  logic       r_ready8, pe8, fe8, ov8;
  logic [4:0] d_in5;
  logic       wrn5, t_empty5, sending5, txd5, rdn5;
  logic [4:0] d_out5;
  logic       r_ready5, pe5, fe5, ov5;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_param #(
    .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .RX_DEPTH(4)
  ) dut8 (
    .clk16x(clk), .clr(clr), .d_in(d_in8), .wrn(wrn8),
    .t_empty(t_empty8), .sending(sending8), .txd(txd8),
    .rxd(rxd8), .rdn(rdn8), .d_out(d_out8), .r_ready(r_ready8),
    .parity_error(pe8), .frame_error(fe8), .overrun(ov8)
  );

  uart_param #(
    .DATA_BITS(5), .PARITY_MODE(2), .STOP_BITS(2), .RX_DEPTH(4)
  ) dut5 (
    .clk16x(clk), .clr(clr), .d_in(d_in5), .wrn(wrn5),
    .t_empty(t_empty5), .sending(sending5), .txd(txd5),
    .rxd(txd5), .rdn(rdn5), .d_out(d_out5), .r_ready(r_ready5),
    .parity_error(pe5), .frame_error(fe5), .overrun(ov5)
  );

  typedef struct {
    logic [7:0] d;
    logic       flip;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } rx_vec_t;

  rx_vec_t vt [6];

`ifdef UART_RX_FIFO_EN
  localparam int NFR = 5;
  localparam int NKEEP = 4;
`else
  localparam int NFR = 2;
  localparam int NKEEP = 1;
`endif

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic flip,
                       input logic stop);
    logic [10:0] f;
    f = {stop, (^d) ^ flip, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      rxd8 = f[b];
      repeat (16) @(negedge clk);
    end
    if (!stop) repeat (32) @(negedge clk);
    rxd8 = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic pop8();
    rdn8 = 1'b0;
    @(negedge clk);
    rdn8 = 1'b1;
  endtask

  // write one character, check the load handshake, then capture the frame
  task automatic tx_run(input logic sel, input logic [7:0] d,
                        input logic [11:0] exp_bits, input int exp_len,
                        input string nm);
    logic [11:0] bits;
    int cyc;
    if (sel) begin d_in5 = d[4:0]; wrn5 = 1'b0; end
    else begin d_in8 = d; wrn8 = 1'b0; end
    @(negedge clk);
    wrn5 = 1'b1;
    wrn8 = 1'b1;
    check({nm, "_t_empty_lo"}, sel ? t_empty5 : t_empty8, 0);
    @(negedge clk);
    check({nm, "_start"},
          sel ? {t_empty5, sending5, txd5} : {t_empty8, sending8, txd8},
          3'b110);
    bits = '0;
    cyc = 0;
    while ((sel ? sending5 : sending8) && cyc < 400) begin
      if (cyc % 16 == 8 && cyc / 16 < 12)
        bits[cyc/16] = sel ? txd5 : txd8;
      @(negedge clk);
      cyc++;
    end
    check({nm, "_bits"}, bits, exp_bits);
    check({nm, "_len"}, cyc, exp_len);
    check({nm, "_idle"}, sel ? txd5 : txd8, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vt[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vt[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vt[5] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};

    clr = 1'b1;
    d_in8 = '0; wrn8 = 1'b1; rxd8 = 1'b1; rdn8 = 1'b1;
    d_in5 = '0; wrn5 = 1'b1; rdn5 = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("reset_flags8", {t_empty8, sending8, txd8, r_ready8, pe8, fe8, ov8},
          7'b1010000);
    check("reset_dout8", d_out8, 0);
    check("reset_flags5", {t_empty5, sending5, txd5, r_ready5, ov5}, 5'b10100);

    // TX: 0xA5, even parity 0, 1 stop -> 11 bits, 176 cycles
    tx_run(1'b0, 8'hA5, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 176, "tx_a5");

    // TX loopback: 0x13, odd parity 0, 2 stops -> 9 bits, 144 cycles
    tx_run(1'b1, 8'h13, {3'b000, 2'b11, 1'b0, 5'h13, 1'b0}, 144, "tx_13");
    repeat (4) @(negedge clk);
    check("lb_ready", r_ready5, 1);
    check("lb_data", d_out5, 5'h13);
    check("lb_err", {pe5, fe5, ov5}, 3'b000);
    rdn5 = 1'b0;
    @(negedge clk);
    rdn5 = 1'b1;
    check("lb_popped", r_ready5, 0);

    // RX vector table on the 8-bit instance
    for (int i = 0; i < 6; i++) begin
      send8(vt[i].d, vt[i].flip, vt[i].stop);
      check($sformatf("rx%0d_ready", i), r_ready8, 1);
      check($sformatf("rx%0d_data", i), d_out8, vt[i].exp_d);
      check($sformatf("rx%0d_pe", i), pe8, vt[i].exp_pe);
      check($sformatf("rx%0d_fe", i), fe8, vt[i].exp_fe);
      pop8();
      check($sformatf("rx%0d_empty", i), {r_ready8, d_out8, pe8, fe8}, 0);
    end

    // glitch shorter than half a bit is not a start bit
    rxd8 = 1'b0;
    repeat (5) @(negedge clk);
    rxd8 = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_ready", r_ready8, 0);

    // overrun: more frames than storage, no reads
    for (int i = 0; i < NFR; i++) send8(8'(i + 1), 1'b0, 1'b1);
    check("ovr_set", ov8, 1);
    for (int i = 0; i < NKEEP; i++) begin
      check($sformatf("ovr_head%0d", i), d_out8, i + 1);
      pop8();
      check($sformatf("ovr_clear%0d", i), ov8, 0);
    end
    check("ovr_drained", r_ready8, 0);

    // reset mid-frame: TX and RX both busy, RX store holding a character
    send8(8'h5A, 1'b0, 1'b1);
    d_in8 = 8'h3C;
    wrn8 = 1'b0;
    @(negedge clk);
    wrn8 = 1'b1;
    rxd8 = 1'b0;
    repeat (60) @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_tx", {t_empty8, sending8, txd8}, 3'b101);
    check("clr_rx", {r_ready8, d_out8, pe8, fe8, ov8}, 0);
    @(negedge clk);
    rxd8 = 1'b1;
    clr = 1'b0;
    repeat (300) @(negedge clk);
    check("post_clr_ready", r_ready8, 0);
    tx_run(1'b0, 8'h3C, {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 176, "tx_3c");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
